// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush with control bubbling, and a saturating stall counter.
module pipe_stage_buf #(
  parameter int                 DATA_W      = 32,
  parameter int                 CTRL_W      = 4,
  parameter int                 RD_W        = 5,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_a_i,
  input  logic [DATA_W-1:0] data_b_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_a_o,
  output logic [DATA_W-1:0] data_b_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // state    | meaning
  // S_EMPTY  | no entry held
  // S_ONE    | main entry valid, drives outputs
  // S_FULL   | main and skid valid, upstream back-pressured
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t              r_state;
  logic [CTRL_W-1:0]   r_main_ctrl, r_skid_ctrl;
  logic [DATA_W-1:0]   r_main_a, r_skid_a;
  logic [DATA_W-1:0]   r_main_b, r_skid_b;
  logic [RD_W-1:0]     r_main_rd, r_skid_rd;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic w_valid, w_ready, w_in_fire, w_out_fire, w_stall;

  assign w_valid    = (r_state != S_EMPTY);
  assign w_ready    = (r_state != S_FULL);
  assign w_in_fire  = valid_i & w_ready;
  assign w_out_fire = w_valid & ready_i;
  assign w_stall    = w_valid & ~ready_i;

  assign valid_o     = w_valid;
  assign ready_o     = w_ready;
  assign ctrl_o      = w_valid ? r_main_ctrl : BUBBLE_CTRL;
  assign data_a_o    = r_main_a;
  assign data_b_o    = r_main_b;
  assign rd_o        = r_main_rd;
  assign stall_cnt_o = r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_EMPTY;
      r_main_ctrl <= '0;
      r_main_a    <= '0;
      r_main_b    <= '0;
      r_main_rd   <= '0;
      r_skid_ctrl <= '0;
      r_skid_a    <= '0;
      r_skid_b    <= '0;
      r_skid_rd   <= '0;
      r_stall_cnt <= '0;
    end else begin
      // Counter ignores flush: it measures downstream back-pressure only.
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);

      if (flush_i) begin
        r_state <= S_EMPTY;
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (w_in_fire) begin
              r_main_ctrl <= ctrl_i;
              r_main_a    <= data_a_i;
              r_main_b    <= data_b_i;
              r_main_rd   <= rd_i;
              r_state     <= S_ONE;
            end
          end
          S_ONE: begin
            if (w_in_fire && w_out_fire) begin
              r_main_ctrl <= ctrl_i;
              r_main_a    <= data_a_i;
              r_main_b    <= data_b_i;
              r_main_rd   <= rd_i;
            end else if (w_in_fire) begin
              r_skid_ctrl <= ctrl_i;
              r_skid_a    <= data_a_i;
              r_skid_b    <= data_b_i;
              r_skid_rd   <= rd_i;
              r_state     <= S_FULL;
            end else if (w_out_fire) begin
              r_state <= S_EMPTY;
            end
          end
          S_FULL: begin
            if (w_out_fire) begin
              r_main_ctrl <= r_skid_ctrl;
              r_main_a    <= r_skid_a;
              r_main_b    <= r_skid_b;
              r_main_rd   <= r_skid_rd;
              r_state     <= S_ONE;
            end
          end
          default: r_state <= S_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a queue models occupancy and FIFO order,
// a separate counter models the saturating stall count (CNT_W=4 here).
module tb_pipe_stage_buf;

  localparam int          DATA_W = 32;
  localparam int          CTRL_W = 4;
  localparam int          RD_W   = 5;
  localparam int          CNT_W  = 4;
  localparam logic [3:0]  BUB    = 4'h5;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [RD_W-1:0]   rd;
  } entry_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [CTRL_W-1:0] ctrl_i, ctrl_o;
  logic [DATA_W-1:0] data_a_i, data_b_i, data_a_o, data_b_o;
  logic [RD_W-1:0]   rd_i, rd_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  entry_t sb[$];
  int     exp_stall;
  int     n_pass;
  int     n_total;
  int     n_pops;

  always #5 clk_i = ~clk_i;

  pipe_stage_buf #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W),
    .BUBBLE_CTRL(BUB), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .ctrl_i(ctrl_i), .data_a_i(data_a_i), .data_b_i(data_b_i), .rd_i(rd_i),
    .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .ctrl_o(ctrl_o), .data_a_o(data_a_o), .data_b_o(data_b_o), .rd_o(rd_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: apply inputs after negedge, check state-derived outputs
  // against the model, then advance the model across the coming posedge.
  task automatic cyc(input logic v, input logic [3:0] c, input logic [31:0] a,
                     input logic rdy, input logic fl);
    entry_t e;
    bit     in_f, out_f;
    @(negedge clk_i);
    valid_i  = v;
    ctrl_i   = c;
    data_a_i = a;
    data_b_i = ~a;
    rd_i     = a[4:0] ^ 5'h1F;
    ready_i  = rdy;
    flush_i  = fl;
    #1;
    chk("valid_o", valid_o, sb.size() != 0);
    chk("ready_o", ready_o, sb.size() < 2);
    chk("stall_cnt", stall_cnt_o, exp_stall);
    if (sb.size() == 0) chk("bubble_ctrl", ctrl_o, BUB);
    out_f = (sb.size() != 0) && rdy;
    in_f  = v && (sb.size() < 2);
    if ((sb.size() != 0) && !rdy && exp_stall != 15) exp_stall++;
    if (fl) begin
      sb.delete();
    end else begin
      if (out_f) begin
        e = sb.pop_front();
        chk("ctrl_o", ctrl_o, e.ctrl);
        chk("data_a_o", data_a_o, e.a);
        chk("data_b_o", data_b_o, e.b);
        chk("rd_o", rd_o, e.rd);
        n_pops++;
      end
      if (in_f) begin
        e.ctrl = c;
        e.a    = a;
        e.b    = ~a;
        e.rd   = a[4:0] ^ 5'h1F;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_pops = 0; exp_stall = 0;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    ctrl_i = '0; data_a_i = '0; data_b_i = '0; rd_i = '0;
    #12;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_ctrl", ctrl_o, BUB);
    chk("rst_data_a", data_a_o, 32'h0);
    chk("rst_rd", rd_o, 5'h0);
    chk("rst_stall", stall_cnt_o, 4'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 4'h3, i, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 0, 1'b1, 1'b0);
    chk("stream_pops", n_pops, 8);
    chk("stream_stall", stall_cnt_o, 4'h0);

    // Skid fill and ordered drain; 0x30 is held upstream until accepted.
    n_pops = 0;
    cyc(1'b1, 4'h1, 32'h10, 1'b0, 1'b0);
    cyc(1'b1, 4'h2, 32'h20, 1'b0, 1'b0);
    cyc(1'b1, 4'h4, 32'h30, 1'b0, 1'b0);
    cyc(1'b1, 4'h4, 32'h30, 1'b0, 1'b0);
    cyc(1'b1, 4'h4, 32'h30, 1'b1, 1'b0);
    cyc(1'b1, 4'h4, 32'h30, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 0, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 0, 1'b1, 1'b0);
    chk("skid_pops", n_pops, 3);
    chk("skid_stall", stall_cnt_o, 4'd3);

    // Flush while FULL with an incoming ctrl=F entry.
    cyc(1'b1, 4'h6, 32'h40, 1'b0, 1'b0);
    cyc(1'b1, 4'h7, 32'h41, 1'b0, 1'b0);
    cyc(1'b1, 4'hF, 32'hDEAD, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 0, 1'b1, 1'b0);
    chk("flush_ctrl", ctrl_o, BUB);
    cyc(1'b1, 4'h8, 32'h50, 1'b1, 1'b0);
    cyc(1'b1, 4'h9, 32'h51, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 0, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 0, 1'b1, 1'b0);

    // Stall counter saturation.
    cyc(1'b1, 4'h2, 32'h60, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'h0, 0, 1'b0, 1'b0);
    chk("sat_stall", stall_cnt_o, 4'hF);
    cyc(1'b0, 4'h0, 0, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 0, 1'b1, 1'b0);

    // Async reset mid-cycle while FULL.
    cyc(1'b1, 4'h1, 32'h70, 1'b0, 1'b0);
    cyc(1'b1, 4'h1, 32'h71, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 0, 1'b0, 1'b0);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_valid", valid_o, 1'b0);
    chk("arst_ready", ready_o, 1'b1);
    chk("arst_ctrl", ctrl_o, BUB);
    chk("arst_data_a", data_a_o, 32'h0);
    chk("arst_stall", stall_cnt_o, 4'h0);
    sb.delete();
    exp_stall = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    n_pops = 0;
    cyc(1'b1, 4'hC, 32'h55, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 0, 1'b1, 1'b0);
    chk("post_rst_pops", n_pops, 1);
    cyc(1'b0, 4'h0, 0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register for the RISC-V core, successor to the fixed-field stage registers (ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle, two data words and a destination-register index from one stage to the next.
- Adds valid/ready handshaking with a 2-entry skid buffer, synchronous flush and bubble insertion on control outputs, and a saturating stall counter.
- Sits between any two pipeline stages; the hazard unit drives flush_i, and downstream back-pressure drives ready_i.

Parameters:
- DATA_W, 32, width of each data word (ALU result, store data).
- CTRL_W, 4, width of control bundle (RegWrite, MemtoReg, MemRead, MemWrite, ...).
- RD_W, 5, width of destination register index.
- BUBBLE_CTRL, 0, control value presented when no valid entry (NOP).
- CNT_W, 16, width of stall counter.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage can accept an entry this cycle.
- ctrl_i  in  CTRL_W  upstream control bundle.
- data_a_i  in  DATA_W  upstream data word A.
- data_b_i  in  DATA_W  upstream data word B.
- rd_i  in  RD_W  upstream destination index.
- flush_i  in  1  discard all held entries and the incoming entry.
- valid_o  out  1  downstream entry valid.
- ready_i  in  1  downstream accepts the entry this cycle.
- ctrl_o  out  CTRL_W  control; BUBBLE_CTRL when valid_o=0.
- data_a_o  out  DATA_W  held data word A.
- data_b_o  out  DATA_W  held data word B.
- rd_o  out  RD_W  held destination index.
- stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0.

Behaviour:
- Storage: main entry (drives outputs) and skid entry. State is EMPTY (none valid), ONE (main valid), or FULL (main and skid valid).
- Handshakes: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Outputs are combinational from state only:
  - ready_o = (state != FULL).
  - valid_o = (state != EMPTY).
  - No combinational path from ready_i or valid_i to any output.
- Transitions on the clock edge, when flush_i=0:
  - EMPTY: in_fire -> main<=input, ONE; otherwise stay EMPTY.
  - ONE, in_fire & out_fire -> main<=input, stay ONE.
  - ONE, in_fire only -> skid<=input, FULL.
  - ONE, out_fire only -> EMPTY.
  - ONE, neither -> hold.
  - FULL: out_fire -> main<=skid, ONE. valid_i is ignored because ready_o=0. Otherwise hold.
- Ordering: strict FIFO; skid contents never bypass main.
- Latency: 1 cycle input-to-output when EMPTY, or when in ONE with out_fire. Full throughput of 1 entry/cycle while ready_i stays high.
- Flush:
  - flush_i=1 -> next state EMPTY regardless of valid_i, ready_i or state. The incoming entry is dropped.
  - ctrl_o = BUBBLE_CTRL from the next cycle.
  - Data/rd registers may retain stale values.
  - flush_i has priority over every other event in the same cycle.
- Bubble: whenever valid_o=0, ctrl_o = BUBBLE_CTRL. data_a_o, data_b_o and rd_o are don't-care.
- Stall counter:
  - Increments by 1 on each edge where valid_o=1 and ready_i=0.
  - Saturates at all-ones, no wrap.
  - Unaffected by flush; cleared only by reset.
- Reset (async, any time including mid-transfer):
  - state=EMPTY, valid_o=0, ready_o=1, ctrl_o=BUBBLE_CTRL.
  - Main/skid data, rd and stall_cnt_o all 0.
  - First edge after rst_i deasserts behaves as from EMPTY.
- Widths: all fields are stored verbatim; no arithmetic except the stall counter.

Test Plan:
- Streaming: ready_i=1, valid_i=1 for 8 cycles with data_a_i=1..8 -> valid_o high from cycle 1, data_a_o=1..8 consecutively, ready_o stays 1, stall_cnt_o=0.
- Skid fill: one entry (A=0x10) held, ready_i=0, second input A=0x20 -> FULL, ready_o=0. Third input A=0x30 held upstream. Raise ready_i -> outputs 0x10, 0x20, 0x30 in order, nothing lost or duplicated, stall_cnt_o counts the low-ready_i cycles.
- Flush in FULL with valid_i=1 (ctrl_i=4'hF) -> next cycle valid_o=0, ctrl_o=BUBBLE_CTRL, ready_o=1. No flushed entry ever appears on the outputs.
- Stall counter saturation with CNT_W=4: valid_o=1, ready_i=0 for 20 cycles -> stall_cnt_o reaches 15 and holds at 15.
- Async reset asserted mid-cycle while FULL -> outputs go to reset values immediately, without waiting for a clock edge. After release, a single input A=0x55 appears one cycle later with valid_o=1.
